// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types and constants for the unified code+data memory arbiter.
// Holds the response-owner encoding and word/byte geometry.
package arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   localparam logic [31:0] RESET_PC   = 32'h0000_3000;
   localparam int          WORD_BYTES = 4;
   localparam int          BYTE_OFF_W = $clog2(WORD_BYTES);

endpackage

// File: rtl/imem_dmem_arbiter_starve_counter.sv
// Saturating count of consecutive denied fetch cycles.
// limit_hit is registered so it is glitch-free when it feeds the grant logic.
module starve_counter #(
   parameter int STARVE_LIM = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic limit_hit
);

   localparam logic [3:0] LIM = 4'(STARVE_LIM);

   logic [3:0] cnt_r;
   logic [3:0] cnt_s;
   logic       limit_r;

   // next count: clear wins, otherwise increment until the limit is reached
   always_comb begin
      cnt_s = cnt_r;
      if (clr) begin
         cnt_s = 4'd0;
      end else if (inc && (cnt_r < LIM)) begin
         cnt_s = cnt_r + 4'd1;
      end else begin
         cnt_s = cnt_r;
      end
   end

   // count and limit flag registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r   <= 4'd0;
         limit_r <= 1'b0;
      end else begin
         cnt_r   <= cnt_s;
         limit_r <= (cnt_s == LIM);
      end
   end

   assign limit_hit = limit_r;

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between fetch (read-only)
// and the MEM stage; data has priority, a starvation counter lets fetch through.
module imem_dmem_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int STARVE_LIM = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   output logic              stall_if,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [3:0]        d_be,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int HI = ADDR_W + BYTE_OFF_W - 1;

   logic              limit_hit_s;
   logic              if_sel_s;
   logic              d_sel_s;
   logic              starve_inc_s;
   logic              starve_clr_s;
   owner_t            resp_owner_r;
   owner_t            resp_owner_s;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [31:0]       mem_wdata_r;
   logic [31:0]       if_rdata_r;
   logic [31:0]       d_rdata_r;
   logic              unused_addr_bits_s;

   // Addresses wrap: byte offset and bits above the RAM size are dropped.
   assign unused_addr_bits_s = ^{if_addr[31:HI+1], if_addr[BYTE_OFF_W-1:0],
                                 d_addr[31:HI+1],  d_addr[BYTE_OFF_W-1:0]};

   // grant selection and fetch stall
   always_comb begin
      d_sel_s  = 1'b0;
      if_sel_s = 1'b0;
      if (reset) begin
         d_sel_s  = 1'b0;
         if_sel_s = 1'b0;
      end else if (d_req && !(if_req && limit_hit_s)) begin
         d_sel_s = 1'b1;
      end else if (if_req) begin
         if_sel_s = 1'b1;
      end else begin
         d_sel_s  = 1'b0;
         if_sel_s = 1'b0;
      end
      if_gnt       = if_sel_s;
      d_gnt        = d_sel_s;
      stall_if     = !reset && if_req && !if_sel_s;
      starve_inc_s = if_req && !if_sel_s;
      starve_clr_s = !if_req || if_sel_s;
   end

   starve_counter #(
      .STARVE_LIM (STARVE_LIM)
   ) u_starve (
      .clk       (clk),
      .reset     (reset),
      .inc       (starve_inc_s),
      .clr       (starve_clr_s),
      .limit_hit (limit_hit_s)
   );

   // RAM port drive; address and write data hold when nobody is granted
   always_comb begin
      mem_en    = if_sel_s | d_sel_s;
      mem_we    = 4'b0000;
      mem_addr  = mem_addr_r;
      mem_wdata = mem_wdata_r;
      if (d_sel_s) begin
         mem_addr  = d_addr[HI:BYTE_OFF_W];
         mem_wdata = d_wdata;
         if (d_we) begin
            mem_we = d_be;
         end else begin
            mem_we = 4'b0000;
         end
      end else if (if_sel_s) begin
         mem_addr = if_addr[HI:BYTE_OFF_W];
      end else begin
         mem_addr = mem_addr_r;
      end
   end

   // owner of next cycle's read data; writes produce no response
   always_comb begin
      resp_owner_s = OWN_NONE;
      if (d_sel_s && !d_we) begin
         resp_owner_s = OWN_D;
      end else if (if_sel_s) begin
         resp_owner_s = OWN_IF;
      end else begin
         resp_owner_s = OWN_NONE;
      end
   end

   // hold registers for RAM port and response owner
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_addr_r   <= '0;
         mem_wdata_r  <= 32'h0;
         resp_owner_r <= OWN_NONE;
      end else begin
         resp_owner_r <= resp_owner_s;
         if (mem_en) begin
            mem_addr_r <= mem_addr;
         end
         if (d_sel_s) begin
            mem_wdata_r <= d_wdata;
         end
      end
   end

   // response steering; the non-owner keeps its last read data
   always_comb begin
      if_rvalid = 1'b0;
      d_rvalid  = 1'b0;
      if_rdata  = if_rdata_r;
      d_rdata   = d_rdata_r;
      if (reset) begin
         if_rdata = 32'h0;
         d_rdata  = 32'h0;
      end else begin
         case (resp_owner_r)
            OWN_IF: begin
               if_rvalid = 1'b1;
               if_rdata  = mem_rdata;
            end
            OWN_D: begin
               d_rvalid = 1'b1;
               d_rdata  = mem_rdata;
            end
            default: if_rvalid = 1'b0;
         endcase
      end
   end

   // last delivered read data per requester
   always_ff @(posedge clk) begin
      if (reset) begin
         if_rdata_r <= 32'h0;
         d_rdata_r  <= 32'h0;
      end else begin
         if (if_rvalid) begin
            if_rdata_r <= mem_rdata;
         end
         if (d_rvalid) begin
            d_rdata_r <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: directed scenarios then random traffic,
// checked against a transaction-level model with its own shadow memory.
module tb_imem_dmem_arbiter;

   localparam int ADDR_W     = 10;
   localparam int STARVE_LIM = 4;
   localparam int DEPTH      = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset;
   logic              if_req;
   logic [31:0]       if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [31:0]       if_rdata;
   logic              stall_if;
   logic              d_req;
   logic              d_we;
   logic [3:0]        d_be;
   logic [31:0]       d_addr;
   logic [31:0]       d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [31:0]       d_rdata;
   logic              mem_en;
   logic [3:0]        mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   always #5 clk = ~clk;

   imem_dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIM(STARVE_LIM)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .stall_if(stall_if),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   function automatic logic [31:0] init_word(input int idx);
      if (idx == 4) return 32'h1122_3344;
      return (idx * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   // RAM environment: synchronous single-port word memory
   logic [31:0] ram [DEPTH];
   bit          written [DEPTH];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we == 4'b0000)
            mem_rdata <= written[mem_addr] ? ram[mem_addr] : init_word(int'(mem_addr));
         else begin
            ram[mem_addr]     <= merge(written[mem_addr] ? ram[mem_addr] : init_word(int'(mem_addr)),
                                       mem_wdata, mem_we);
            written[mem_addr] <= 1'b1;
         end
      end
   end

   // reference model state
   logic [31:0] shadow [DEPTH];
   int          starve;
   int          pend_own;        // 0 none, 1 fetch, 2 data
   logic [31:0] pend_data;
   logic [31:0] last_if_rd, last_d_rd, last_maddr, last_wdata;
   int          n_cmp = 0;
   int          n_err = 0;
   logic        obs_if_gnt;
   logic [31:0] obs_maddr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input bit r, input bit ifr, input logic [31:0] ifa,
                        input bit dr, input bit dwe, input logic [3:0] be,
                        input logic [31:0] da, input logic [31:0] wd);
      bit          eg_if, eg_d;
      int          wi_if, wi_d;
      logic [31:0] e_if_rd, e_d_rd;
      reset = r; if_req = ifr; if_addr = ifa;
      d_req = dr; d_we = dwe; d_be = be; d_addr = da; d_wdata = wd;
      @(negedge clk);
      wi_if = int'((ifa / 32'd4) % 32'(DEPTH));
      wi_d  = int'((da / 32'd4) % 32'(DEPTH));
      eg_if = 1'b0; eg_d = 1'b0;
      if (!r) begin
         if (ifr && dr) begin
            if (starve == STARVE_LIM) eg_if = 1'b1; else eg_d = 1'b1;
         end else begin
            eg_if = ifr;
            eg_d  = dr;
         end
      end
      e_if_rd = r ? 32'h0 : ((pend_own == 1) ? pend_data : last_if_rd);
      e_d_rd  = r ? 32'h0 : ((pend_own == 2) ? pend_data : last_d_rd);
      chk("if_gnt",    32'(if_gnt),    32'(eg_if));
      chk("d_gnt",     32'(d_gnt),     32'(eg_d));
      chk("stall_if",  32'(stall_if),  32'(!r && ifr && !eg_if));
      chk("mem_en",    32'(mem_en),    32'(eg_if || eg_d));
      chk("mem_we",    32'(mem_we),    32'((eg_d && dwe) ? be : 4'b0000));
      chk("mem_addr",  32'(mem_addr),  eg_d ? 32'(wi_d) : (eg_if ? 32'(wi_if) : last_maddr));
      chk("mem_wdata", mem_wdata,      eg_d ? wd : last_wdata);
      chk("if_rvalid", 32'(if_rvalid), 32'(!r && pend_own == 1));
      chk("d_rvalid",  32'(d_rvalid),  32'(!r && pend_own == 2));
      chk("if_rdata",  if_rdata,       e_if_rd);
      chk("d_rdata",   d_rdata,        e_d_rd);
      obs_if_gnt = if_gnt;
      obs_maddr  = 32'(mem_addr);
      if (r) begin
         last_if_rd = 32'h0; last_d_rd = 32'h0; last_maddr = 32'h0; last_wdata = 32'h0;
         starve = 0; pend_own = 0;
      end else begin
         last_if_rd = e_if_rd;
         last_d_rd  = e_d_rd;
         if (!ifr || eg_if) starve = 0;
         else if (starve < STARVE_LIM) starve = starve + 1;
         pend_own = 0;
         if (eg_if) begin pend_own = 1; pend_data = shadow[wi_if]; last_maddr = 32'(wi_if); end
         if (eg_d) begin
            last_maddr = 32'(wi_d);
            last_wdata = wd;
            if (dwe) shadow[wi_d] = merge(shadow[wi_d], wd, be);
            else begin pend_own = 2; pend_data = shadow[wi_d]; end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
      starve = 0; pend_own = 0; pend_data = 32'h0;
      last_if_rd = 32'h0; last_d_rd = 32'h0; last_maddr = 32'h0; last_wdata = 32'h0;
      reset = 1'b1; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
      d_be = 4'b0000; d_addr = 32'h0; d_wdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

      // fetch only, sequential words
      cycle(1'b0, 1'b1, arb_pkg::RESET_PC,         1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      cycle(1'b0, 1'b1, arb_pkg::RESET_PC + 32'd4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0,                     1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

      // partial write then read-back
      cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h0000_0010, 32'hAABB_CCDD);
      cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h0000_0010, 32'h0);
      chk("merge_rvalid", 32'(d_rvalid), 32'h1);
      chk("merge_rdata",  d_rdata,       32'h1122_CCDD);
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

      // continuous conflict: fetch gets through every fifth cycle
      for (int k = 0; k < 10; k++) begin
         cycle(1'b0, 1'b1, arb_pkg::RESET_PC, 1'b1, 1'b0, 4'h0, 32'h0000_0020 + 32'(4 * k), 32'h0);
         chk("conflict_if_gnt", 32'(obs_if_gnt), 32'((k == 4) || (k == 9)));
      end
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

      // alternating owners
      cycle(1'b0, 1'b1, arb_pkg::RESET_PC, 1'b0, 1'b0, 4'h0, 32'h0,         32'h0);
      cycle(1'b0, 1'b0, 32'h0,             1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0);
      cycle(1'b0, 1'b0, 32'h0,             1'b0, 1'b0, 4'h0, 32'h0,         32'h0);

      // reset lands on a pending fetch response
      cycle(1'b0, 1'b1, arb_pkg::RESET_PC,         1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      cycle(1'b1, 1'b1, arb_pkg::RESET_PC,         1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
      cycle(1'b0, 1'b1, arb_pkg::RESET_PC + 32'd4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      chk("post_reset_if_gnt", 32'(obs_if_gnt), 32'h1);

      // address wrap
      cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000_1003, 32'h0);
      chk("wrap_addr", obs_maddr, 32'h0);

      // random traffic over a small address window so hits and overwrites occur
      for (int n = 0; n < 400; n++) begin
         cycle(($urandom_range(0, 49) == 0),
               1'($urandom_range(0, 1)),
               ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)),
               ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2),
               $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
